// File: rtl/dmem_byte_arbiter_if.sv
// Bus bundle between the two word requesters, the byte-wide data memory and the arbiter.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface dmem_byte_arbiter_if #(
   parameter int ADDR_W = 7
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [31:0]       p0_wdata;
   logic              p0_done;
   logic [31:0]       p0_rdata;
   logic              p0_stall;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [31:0]       p1_wdata;
   logic              p1_done;
   logic [31:0]       p1_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              busy;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_done, p0_rdata, p0_stall,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p1_done, p1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_done, p0_rdata, p0_stall,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p1_done, p1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/dmem_byte_arbiter.sv
// Two-port 32-bit word arbiter in front of a byte-wide data memory; each word becomes four
// big-endian byte accesses. Define DMEM_RR_ARB_EN for round-robin instead of port-0 priority.
module dmem_byte_arbiter #(
   parameter int ADDR_W = 7,
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   dmem_byte_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

   // Read capture assumes single-cycle memory; other latencies never capture.
   localparam bit LAT_OK = (RD_LAT == 1);

   state_t            state, state_nxt;
   logic [1:0]        k;
   logic              any_req, win_port;
   logic              lat_we, lat_port;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic              rd_vld_p1;
   logic [23:0]       asm_p1;
   logic [31:0]       word_p1;
   logic              rd_done;
   logic [31:0]       p0_rdata_q, p1_rdata_q;
   logic              p0_done_c;

   assign any_req = bus.p0_req | bus.p1_req;

`ifdef DMEM_RR_ARB_EN
   logic rr_ptr;

   // Contention goes to the port that did not win last; a lone requester always wins.
   always_comb win_port = (bus.p0_req & bus.p1_req) ? ~rr_ptr : bus.p1_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= 1'b0;
      else if (state == S_IDLE && any_req)
         rr_ptr <= win_port;
   end
`else
   always_comb win_port = ~bus.p0_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_ISSUE;
         S_ISSUE: if (k == 2'd3) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k         <= 2'd0;
         rd_vld_p1 <= 1'b0;
      end else begin
         k         <= (state == S_ISSUE) ? k + 2'd1 : 2'd0;
         rd_vld_p1 <= (state == S_ISSUE) & ~lat_we & LAT_OK;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && any_req) begin
         lat_port  <= win_port;
         lat_we    <= win_port ? bus.p1_we    : bus.p0_we;
         lat_addr  <= win_port ? bus.p1_addr  : bus.p0_addr;
         lat_wdata <= win_port ? bus.p1_wdata : bus.p0_wdata;
      end
   end

   // p1 stage: byte returned one cycle after its issue, shifted in MSB first
   always_ff @(posedge clk) begin
      if (rd_vld_p1)
         asm_p1 <= {asm_p1[15:0], bus.mem_rdata};
   end

   assign word_p1 = {asm_p1, bus.mem_rdata};
   assign rd_done = (state == S_DONE) & ~lat_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else if (rd_done) begin
         if (lat_port) p1_rdata_q <= word_p1;
         else          p0_rdata_q <= word_p1;
      end
   end

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = 8'h00;
      bus.p1_done   = 1'b0;
      p0_done_c     = 1'b0;
      bus.p0_rdata  = p0_rdata_q;
      bus.p1_rdata  = p1_rdata_q;
      case (state)
         S_ISSUE: begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = lat_we;
            bus.mem_addr = lat_addr + ADDR_W'(k);
            case (k)
               2'd0:    bus.mem_wdata = lat_wdata[31:24];
               2'd1:    bus.mem_wdata = lat_wdata[23:16];
               2'd2:    bus.mem_wdata = lat_wdata[15:8];
               default: bus.mem_wdata = lat_wdata[7:0];
            endcase
         end
         S_DONE: begin
            p0_done_c   = ~lat_port;
            bus.p1_done = lat_port;
            // Last byte bypasses the register so rdata is valid alongside done.
            if (rd_done) begin
               if (lat_port) bus.p1_rdata = word_p1;
               else          bus.p0_rdata = word_p1;
            end
         end
         default: ;
      endcase
   end

   assign bus.p0_done  = p0_done_c;
   assign bus.p0_stall = bus.p0_req & ~p0_done_c;
   assign bus.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_byte_arbiter.sv
// Directed bench for dmem_byte_arbiter (default fixed-priority build) with a byte memory model.
module tb_dmem_byte_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dmem_byte_arbiter_if #(.ADDR_W(7)) bus ();

   dmem_byte_arbiter #(.ADDR_W(7), .RD_LAT(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] mem [128];

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end
   end

   int          vectors = 0;
   int          errs    = 0;
   int          lat;
   int          n_iss;
   int          d0, d1;
   bit          stall_bad;
   bit          stall_at_done;
   logic [6:0]  iss_addr [8];
   logic [31:0] rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called one step after a rising edge with the arbiter idle; returns in the next idle cycle.
   task automatic txn(input bit port, input bit we, input logic [6:0] addr,
                      input logic [31:0] wd, input bit tamper);
      if (!port) begin
         bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
      end else begin
         bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
      end
      lat = 0; n_iss = 0; stall_bad = 1'b0; stall_at_done = 1'b1;
      #1;
      if (!port && !bus.p0_stall) stall_bad = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         lat++;
         if (tamper && lat == 1) begin
            bus.p0_addr  = 7'd100;
            bus.p0_wdata = 32'hFFFF_FFFF;
         end
         if (bus.mem_en && n_iss < 8) begin
            iss_addr[n_iss] = bus.mem_addr;
            n_iss++;
         end
         if (port ? bus.p1_done : bus.p0_done) break;
         if (!port && !bus.p0_stall) stall_bad = 1'b1;
      end
      stall_at_done = bus.p0_stall;
      rd = port ? bus.p1_rdata : bus.p0_rdata;
      if (!port) bus.p0_req = 1'b0;
      else       bus.p1_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      bus.mem_rdata = 8'h00;
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",     32'(bus.busy),     32'd0);
      check("rst_mem_en",   32'(bus.mem_en),   32'd0);
      check("rst_p0_done",  32'(bus.p0_done),  32'd0);
      check("rst_p1_done",  32'(bus.p1_done),  32'd0);
      check("rst_p0_stall", 32'(bus.p0_stall), 32'd0);
      check("rst_p0_rdata", bus.p0_rdata,      32'h0);
      check("rst_p1_rdata", bus.p1_rdata,      32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // p0 write then read of one word
      txn(1'b0, 1'b1, 7'd8, 32'hDEAD_BEEF, 1'b0);
      check("p0_wr_lat",      32'(lat),           32'd5);
      check("p0_wr_stall",    32'(stall_bad),     32'd0);
      check("p0_stall_done",  32'(stall_at_done), 32'd0);
      check("p0_wr_bytes",    {mem[8], mem[9], mem[10], mem[11]}, 32'hDEAD_BEEF);
      txn(1'b0, 1'b0, 7'd8, 32'h0, 1'b0);
      check("p0_rd_lat",      32'(lat),           32'd5);
      check("p0_rd_stall",    32'(stall_bad),     32'd0);
      check("p0_rd_data",     rd,                 32'hDEAD_BEEF);

      // p1 write straddling the top of memory
      txn(1'b1, 1'b1, 7'd126, 32'h1122_3344, 1'b0);
      check("wrap_lat",       32'(lat),           32'd5);
      check("wrap_n_issue",   32'(n_iss),         32'd4);
      check("wrap_addrs",     32'({iss_addr[0], iss_addr[1], iss_addr[2], iss_addr[3]}),
                              32'({7'd126, 7'd127, 7'd0, 7'd1}));
      check("wrap_bytes",     {mem[126], mem[127], mem[0], mem[1]}, 32'h1122_3344);
      txn(1'b1, 1'b0, 7'd126, 32'h0, 1'b0);
      check("wrap_rd_data",   rd,                 32'h1122_3344);
      check("p0_rd_kept",     bus.p0_rdata,       32'hDEAD_BEEF);

      // both ports hold read requests: port 0 keeps winning
      bus.p0_we = 1'b0; bus.p0_addr = 7'd8;   bus.p0_req = 1'b1;
      bus.p1_we = 1'b0; bus.p1_addr = 7'd126; bus.p1_req = 1'b1;
      d0 = 0; d1 = 0;
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         if (bus.p0_done) d0++;
         if (bus.p1_done) d1++;
      end
      check("prio_p0_grants", 32'(d0), 32'd3);
      check("prio_p1_grants", 32'(d1), 32'd0);
      check("prio_p0_rdata",  bus.p0_rdata, 32'hDEAD_BEEF);
      bus.p0_req = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         lat++;
         if (bus.p1_done) break;
      end
      check("prio_p1_lat",    32'(lat),       32'd5);
      check("prio_p1_rdata",  bus.p1_rdata,   32'h1122_3344);
      bus.p1_req = 1'b0;
      @(posedge clk); #1;

      // read data retention across other traffic
      txn(1'b1, 1'b1, 7'd40, 32'hCAFE_F00D, 1'b0);
      txn(1'b1, 1'b0, 7'd40, 32'h0, 1'b0);
      check("p1_rd_cafe",     rd,             32'hCAFE_F00D);
      txn(1'b0, 1'b1, 7'd60, 32'h5566_7788, 1'b0);
      check("ret_p1_rdata",   bus.p1_rdata,   32'hCAFE_F00D);
      check("ret_p0_rdata",   bus.p0_rdata,   32'hDEAD_BEEF);
      check("ret_wr_bytes",   {mem[60], mem[61], mem[62], mem[63]}, 32'h5566_7788);

      // operands changed after the latch must be ignored
      txn(1'b0, 1'b1, 7'd20, 32'hA1B2_C3D4, 1'b1);
      check("latch_lat",      32'(lat),       32'd5);
      check("latch_bytes",    {mem[20], mem[21], mem[22], mem[23]}, 32'hA1B2_C3D4);
      check("latch_mem100",   32'(mem[100]),  32'h0);

      // reset during byte 2 of a write
      bus.p0_we = 1'b1; bus.p0_addr = 7'd30; bus.p0_wdata = 32'h0BAD_CAFE; bus.p0_req = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("mid_k2_addr",    32'(bus.mem_addr), 32'd32);
      rst_n = 1'b0;
      bus.p0_req = 1'b0;
      #1;
      check("mid_rst_busy",   32'(bus.busy),   32'd0);
      check("mid_rst_en",     32'(bus.mem_en), 32'd0);
      @(posedge clk); #1;
      check("mid_rst_busy2",  32'(bus.busy),   32'd0);
      check("mid_rst_en2",    32'(bus.mem_en), 32'd0);
      check("mid_rst_done",   32'(bus.p0_done), 32'd0);
      check("mid_rst_rdata",  bus.p0_rdata,    32'h0);
      check("mid_rst_bytes",  32'({mem[30], mem[31], mem[32]}), 32'h000B_AD00);
      rst_n = 1'b1;
      @(posedge clk); #1;
      txn(1'b0, 1'b0, 7'd30, 32'h0, 1'b0);
      check("post_rst_lat",   32'(lat),        32'd5);
      check("post_rst_rdata", rd,              32'h0BAD_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/dmem_byte_arbiter.md
Name: dmem_byte_arbiter

Overview:
- Controller in front of the byte-wide (8-bit x DEPTH) data memory.
- Arbitrates 32-bit word requests from two requesters:
  - port 0: pipeline MEM stage
  - port 1: loader/debug port
- Sequences each word access as four big-endian byte accesses: byte addr+0 carries [31:24] … addr+3 carries [7:0].
- Drives the memory's single byte port and a stall to the pipeline.

Parameters:
- ADDR_W, 7: byte address width; memory DEPTH = 2**ADDR_W (128 bytes).
- RD_LAT, 1: memory read latency in cycles; fixed at 1, other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- p0_req  in  1  port 0 request, level
- p0_we  in  1  port 0: 1 = write, 0 = read
- p0_addr  in  ADDR_W  port 0 byte address of word MSB
- p0_wdata  in  32  port 0 write word
- p0_done  out  1  port 0 transaction-complete pulse
- p0_rdata  out  32  port 0 read word
- p0_stall  out  1  p0_req & ~p0_done, to pipeline hazard unit
- p1_req / p1_we / p1_addr / p1_wdata / p1_done / p1_rdata  as port 0, no stall output
- mem_en  out  1  byte access strobe
- mem_we  out  1  byte write enable, valid with mem_en
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte write data
- mem_rdata  in  8  byte read data, valid one cycle after mem_en & ~mem_we
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; p0_rdata = p1_rdata = 0; FSM = IDLE; byte index = 0; rr pointer = port 0.
- FSM states: IDLE -> ISSUE (byte index k = 0..3) -> DONE -> IDLE.
- IDLE:
  - Samples requests and selects a winner.
  - Latches the winner's we, addr, wdata and port id.
  - Goes to ISSUE with k = 0.
  - No request: stay in IDLE.
- Arbitration: fixed priority, port 0 wins over port 1 (see Optional Feature).
- ISSUE:
  - Each cycle: mem_en = 1, mem_we = latched we, mem_addr = (addr + k) mod 2**ADDR_W (wrap-around, no error), mem_wdata = wdata byte k (k = 0 -> [31:24]).
  - k increments each cycle; after k = 3 go to DONE.
- Read capture: mem_rdata captured one cycle after each issue (cycles ISSUE k=1..3 and DONE) into a 32-bit shift assembly.
- DONE:
  - mem_en = 0.
  - Winner's done = 1 for exactly one cycle.
  - On reads, winner's rdata updates in the same cycle done is high: the last byte is merged combinationally from mem_rdata and registered.
  - Always goes to IDLE.
- Latency: request sampled in IDLE at cycle T; issues at T+1..T+4; done at T+5; next arbitration at T+6.
  - Back-to-back throughput: one word per 6 cycles.
- Request handling:
  - Requester holds req and operands until it sees done; it must drop req in the cycle after done, or it is re-arbitrated.
  - Operand changes after the latch are ignored.
  - Deasserting req mid-transaction does not abort it; done is still pulsed.
- Read data retention: rdata of each port is held until that port's next read completes. Writes and other-port traffic do not alter it.
- Stall: p0_stall is combinational; it is high while p0_req is pending or in service, and low in the done cycle.
- Reset mid-operation: immediately returns to IDLE with all outputs 0. No done is issued. Partially written bytes remain in memory.

Optional Feature:
- Macro: DMEM_RR_ARB_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer holds the last-granted port.
  - When both request in IDLE, the other port wins.
  - A single requester always wins.
- Undefined: fixed priority, port 0 over port 1; pointer logic absent.

Test Plan:
- Write 0xDEADBEEF to addr 8 via p0, then read addr 8 via p0 -> bytes 8..11 = DE,AD,BE,EF; read p0_rdata = 0xDEADBEEF; p0_done at T+5 each time; p0_stall high T..T+4.
- Write 0x11223344 at addr 126 via p1 -> mem_addr sequence 126,127,0,1; read back at 126 = 0x11223344.
- p0 and p1 request reads simultaneously with req held after done:
  - without macro: p0 served twice before p1 ever served while p0 keeps requesting;
  - with DMEM_RR_ARB_EN: grants alternate p0,p1,p0.
- p1 read of 0xCAFEF00D, then p0 write elsewhere -> p1_rdata stays 0xCAFEF00D; p0_rdata unchanged.
- Change p0_addr and p0_wdata during ISSUE -> accesses use latched values only.
- Assert rst_n = 0 during ISSUE k = 2 -> next cycle busy = 0, mem_en = 0, no done pulse; fresh request after release completes normally in 5 cycles.
